// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle for the N-input round-robin arbiter: N slave lanes in, one master lane out.
interface axis_rr_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 2
);
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            m_tvalid;
  logic            m_tready;
  logic            busy;

  // Arbiter view: consumes the input lanes, drives the merged output.
  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tlast, m_tid, m_tvalid, busy
  );

  // Environment view: sources the input lanes and sinks the merged output.
  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tlast, m_tid, m_tvalid, busy
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter with packet locking: one idle arbitration cycle,
// then the granted input is passed through combinationally until its tlast beat.
module axis_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  axis_rr_arbiter_if.master    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q,   ptr_d;

  logic          req_any;
  logic [IW-1:0] req_pick;
  logic          hi_found, lo_found;
  logic [IW-1:0] hi_idx,   lo_idx;
  logic [IW-1:0] ptr_wrap;
  logic          beat;

  // Rotating priority: the lowest requester at or above ptr wins, otherwise the
  // lowest requester overall, which is the ptr..N-1,0..ptr-1 search order.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.s_tvalid[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IW'(i);
        end
        if (!hi_found && (IW'(i) >= ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    req_any  = lo_found;
    req_pick = hi_found ? hi_idx : lo_idx;
  end

  // Wrap at N rather than 2^IW so non-power-of-two widths never point out of range.
  always_comb begin
    if (grant_q == IW'(N - 1)) begin
      ptr_wrap = '0;
    end else begin
      ptr_wrap = grant_q + IW'(1);
    end
  end

  always_comb begin
    bus.m_tdata  = '0;
    bus.m_tlast  = 1'b0;
    bus.m_tvalid = 1'b0;
    bus.m_tid    = '0;
    bus.s_tready = '0;
    bus.busy     = 1'b0;
    if (state_q == LOCK) begin
      bus.m_tid = grant_q;
      bus.busy  = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (grant_q == IW'(i)) begin
          bus.m_tdata     = bus.s_tdata[i*DW +: DW];
          bus.m_tlast     = bus.s_tlast[i];
          bus.m_tvalid    = bus.s_tvalid[i];
          bus.s_tready[i] = bus.m_tready;
        end
      end
    end
  end

  assign beat = bus.m_tvalid & bus.m_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = req_pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (beat && bus.m_tlast) begin
          state_d = IDLE;
          ptr_d   = ptr_wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (N=4, DW=32): hand-computed grants, data and handshakes.
module tb_axis_rr_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] beats[$];
  logic [31:0] exp_beats[4];
  logic        rdy;
  int unsigned b;

  axis_rr_arbiter_if #(.N(4), .DW(32), .IW(2)) bus ();

  axis_rr_arbiter #(.N(4), .DW(32), .IW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted output beat outside reset.
  always @(posedge clk) begin
    if (!reset && bus.m_tvalid && bus.m_tready) beats.push_back(bus.m_tdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int unsigned i, input logic [31:0] d);
    bus.s_tdata[i*32 +: 32] = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset        = 1'b1;
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    tick();
    tick();
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_m_tid",    64'(bus.m_tid),    64'd0);
    chk("rst_m_tlast",  64'(bus.m_tlast),  64'd0);
    chk("rst_m_tdata",  64'(bus.m_tdata),  64'd0);
    reset = 1'b0;

    // Input 0, 3-beat packet.
    bus.s_tvalid = 4'b0001;
    lane(0, 32'h10);
    #1;
    chk("t1_idle_valid", 64'(bus.m_tvalid), 64'd0);
    chk("t1_idle_ready", 64'(bus.s_tready), 64'd0);
    tick();
    chk("t1_b0_data",  64'(bus.m_tdata),  64'h10);
    chk("t1_b0_tid",   64'(bus.m_tid),    64'd0);
    chk("t1_b0_busy",  64'(bus.busy),     64'd1);
    chk("t1_b0_ready", 64'(bus.s_tready), 64'b0001);
    tick();
    lane(0, 32'h11);
    #1;
    chk("t1_b1_data",  64'(bus.m_tdata),  64'h11);
    chk("t1_b1_valid", 64'(bus.m_tvalid), 64'd1);
    tick();
    lane(0, 32'h12);
    bus.s_tlast = 4'b0001;
    #1;
    chk("t1_b2_data", 64'(bus.m_tdata), 64'h12);
    chk("t1_b2_last", 64'(bus.m_tlast), 64'd1);
    tick();
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    #1;
    chk("t1_end_busy",  64'(bus.busy),     64'd0);
    chk("t1_end_valid", 64'(bus.m_tvalid), 64'd0);

    // ptr is now 1: with inputs 0 and 1 requesting, 1 wins, then 0.
    for (int unsigned i = 0; i < 4; i++) lane(i, 32'hA0 + i);
    bus.s_tlast  = 4'b1111;
    bus.s_tvalid = 4'b0011;
    #1;
    tick();
    chk("ptr1_tid",  64'(bus.m_tid),   64'd1);
    chk("ptr1_data", 64'(bus.m_tdata), 64'hA1);
    tick();
    chk("ptr1_gap", 64'(bus.m_tvalid), 64'd0);
    tick();
    chk("ptr2_tid", 64'(bus.m_tid), 64'd0);
    tick();
    bus.s_tvalid = '0;

    // One-cycle reset restores ptr to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_busy", 64'(bus.busy), 64'd0);

    // All four inputs request continuously with single-beat packets.
    bus.s_tvalid = 4'b1111;
    for (int unsigned k = 0; k < 8; k++) begin
      #1;
      chk("t2_idle", 64'(bus.m_tvalid), 64'd0);
      tick();
      chk("t2_tid",  64'(bus.m_tid),   64'(k % 4));
      chk("t2_data", 64'(bus.m_tdata), 64'(32'hA0 + (k % 4)));
      tick();
    end
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;

    // Input 2, 4-beat packet, m_tready toggling 1,0,1,0...
    beats.delete();
    bus.s_tvalid = 4'b0100;
    lane(2, 32'h20);
    #1;
    tick();
    b = 0;
    for (int unsigned c = 0; c < 7; c++) begin
      rdy = (c % 2 == 0);
      bus.m_tready = rdy;
      lane(2, 32'h20 + b);
      bus.s_tlast = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      chk("t3_data",  64'(bus.m_tdata),  64'(32'h20 + b));
      chk("t3_tid",   64'(bus.m_tid),    64'd2);
      chk("t3_ready", 64'(bus.s_tready), rdy ? 64'b0100 : 64'd0);
      tick();
      if (rdy) b++;
    end
    bus.m_tready = 1'b1;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    #1;
    chk("t3_end_busy", 64'(bus.busy),     64'd0);
    chk("t3_nbeats",   64'(beats.size()), 64'd4);
    if (beats.size() == 4) begin
      for (int unsigned j = 0; j < 4; j++) chk("t3_beat", 64'(beats[j]), 64'(32'h20 + j));
    end

    // ptr=3: input 1 granted after wrap; 0 and 3 join mid-packet.
    bus.s_tvalid = 4'b0010;
    lane(1, 32'h40);
    #1;
    tick();
    chk("t4_tid", 64'(bus.m_tid), 64'd1);
    tick();
    lane(1, 32'h41);
    lane(0, 32'h50);
    lane(3, 32'h53);
    bus.s_tlast  = 4'b1001;
    bus.s_tvalid = 4'b1011;
    #1;
    chk("t4_hold_tid",   64'(bus.m_tid),    64'd1);
    chk("t4_hold_ready", 64'(bus.s_tready), 64'b0010);
    chk("t4_hold_data",  64'(bus.m_tdata),  64'h41);
    tick();
    lane(1, 32'h42);
    bus.s_tlast = 4'b1011;
    #1;
    chk("t4_last_data", 64'(bus.m_tdata), 64'h42);
    tick();
    bus.s_tvalid = 4'b1001;
    #1;
    chk("t4_gap", 64'(bus.m_tvalid), 64'd0);
    tick();
    chk("t4_next_tid",  64'(bus.m_tid),   64'd3);
    chk("t4_next_data", 64'(bus.m_tdata), 64'h53);
    tick();
    tick();
    chk("t4_then_tid",  64'(bus.m_tid),   64'd0);
    chk("t4_then_data", 64'(bus.m_tdata), 64'h50);
    tick();
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;

    // ptr=1 is the only requester; it drops valid for three cycles mid-packet.
    beats.delete();
    bus.s_tvalid = 4'b0010;
    lane(1, 32'h60);
    #1;
    tick();
    chk("t5_tid",  64'(bus.m_tid),   64'd1);
    chk("t5_data", 64'(bus.m_tdata), 64'h60);
    tick();
    lane(1, 32'h61);
    bus.s_tvalid = '0;
    for (int unsigned s = 0; s < 3; s++) begin
      #1;
      chk("t5_stall_valid", 64'(bus.m_tvalid), 64'd0);
      chk("t5_stall_tid",   64'(bus.m_tid),    64'd1);
      chk("t5_stall_busy",  64'(bus.busy),     64'd1);
      tick();
    end
    bus.s_tvalid = 4'b0010;
    #1;
    chk("t5_resume_valid", 64'(bus.m_tvalid), 64'd1);
    chk("t5_resume_data",  64'(bus.m_tdata),  64'h61);
    tick();
    lane(1, 32'h62);
    bus.s_tlast = 4'b0010;
    #1;
    chk("t5_last", 64'(bus.m_tlast), 64'd1);
    tick();
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    #1;
    chk("t5_end_busy", 64'(bus.busy),     64'd0);
    chk("t5_nbeats",   64'(beats.size()), 64'd3);

    // ptr=2: input 3, 5-beat packet abandoned by reset during beat 2.
    beats.delete();
    bus.s_tvalid = 4'b1000;
    lane(3, 32'h70);
    #1;
    tick();
    chk("t6_tid", 64'(bus.m_tid), 64'd3);
    tick();
    lane(3, 32'h71);
    #1;
    chk("t6_b1_data", 64'(bus.m_tdata), 64'h71);
    tick();
    lane(3, 32'h72);
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.m_tvalid), 64'd0);
    chk("t6_rst_ready", 64'(bus.s_tready), 64'd0);
    chk("t6_rst_busy",  64'(bus.busy),     64'd0);
    bus.s_tvalid = 4'b0101;
    bus.s_tlast  = 4'b0101;
    lane(0, 32'h80);
    lane(2, 32'h82);
    #1;
    tick();
    chk("t6_g0_tid",  64'(bus.m_tid),   64'd0);
    chk("t6_g0_data", 64'(bus.m_tdata), 64'h80);
    tick();
    chk("t6_gap", 64'(bus.m_tvalid), 64'd0);
    tick();
    chk("t6_g1_tid",  64'(bus.m_tid),   64'd2);
    chk("t6_g1_data", 64'(bus.m_tdata), 64'h82);
    tick();
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    #1;
    exp_beats[0] = 32'h70;
    exp_beats[1] = 32'h71;
    exp_beats[2] = 32'h80;
    exp_beats[3] = 32'h82;
    chk("t6_nbeats", 64'(beats.size()), 64'd4);
    if (beats.size() == 4) begin
      for (int unsigned j = 0; j < 4; j++) chk("t6_beat", 64'(beats[j]), 64'(exp_beats[j]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-input AXI-Stream round-robin arbiter with packet locking.
- Selects one requesting input, forwards the whole packet (through the beat with tlast), then re-arbitrates.
- Sits directly upstream of the elastic-buffer stage: its m_* side drives that buffer's s_valid/s_ready/data input.
- Registered grant, combinational data path while locked; never splits a packet.

Parameters:
- N, 4, number of input streams (2..16).
- DW, 32, tdata width in bits.
- IW, 2, width of m_tid; must equal ceil(log2(N)), minimum 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tdata  input  N*DW  input data; stream i occupies bits [i*DW +: DW].
- s_tvalid  input  N  per-input valid.
- s_tlast  input  N  per-input end-of-packet.
- s_tready  output  N  per-input ready.
- m_tdata  output  DW  output data.
- m_tlast  output  1  output end-of-packet.
- m_tid  output  IW  index of the granted input.
- m_tvalid  output  1  output valid.
- m_tready  input  1  output ready from the downstream elastic buffer.
- busy  output  1  high while in LOCK.

Behaviour:
- State machine: IDLE, LOCK.
- Registers: state, grant[IW-1:0], ptr[IW-1:0] (highest-priority candidate).
- Reset (sampled on clk edge while reset=1): state=IDLE, grant=0, ptr=0.
- Outputs during and after reset until the first grant: m_tvalid=0, s_tready=0 on all inputs, busy=0, m_tid=0, m_tlast=0, m_tdata=0.

IDLE:
- m_tvalid=0, all s_tready=0, m_tdata/m_tlast=0.
- If any s_tvalid is set, grant <= first index i with s_tvalid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N). State <= LOCK.
- If no s_tvalid is set, stay in IDLE; ptr is unchanged.

LOCK:
- m_tvalid=s_tvalid[grant], m_tdata=s_tdata[grant], m_tlast=s_tlast[grant], m_tid=grant.
- s_tready[grant]=m_tready; all other s_tready=0.
- busy=1.
- Beat = m_tvalid & m_tready.
- Beat with m_tlast=1: state <= IDLE, ptr <= grant+1 wrapping N-1 -> 0 (for non-power-of-2 N, wrap at N, not at 2^IW).
- Beat with m_tlast=0: stay in LOCK, grant unchanged.
- Granted input deasserting s_tvalid mid-packet: stay in LOCK; m_tvalid=0; no timeout, no re-arbitration.
- Requests from other inputs are ignored until tlast is accepted.

Timing and latency:
- Arbitration costs exactly one IDLE cycle between packets.
- First beat of a packet can transfer in the cycle after the request is first seen in IDLE.
- Packet of L beats with m_tready held at 1 occupies L+1 cycles.
- m_* is combinational from s_* and m_tready in LOCK. This is acceptable only because the downstream elastic buffer registers the path.

Handshake rules:
- Data, last and tid are stable while m_tvalid=1 and m_tready=0, provided the upstream source obeys AXI-S.
- The arbiter never drops m_tvalid on its own while the granted input holds s_tvalid.

Boundary conditions:
- Single-beat packet (tlast on first beat): LOCK for one cycle, then IDLE.
- Ptr equals the only requester: that input is granted.
- Ptr points at a non-requester: search wraps past N-1 correctly.
- Same input requesting continuously while others wait: it is not re-granted until every other waiting input has been served (round-robin fairness).
- Reset asserted mid-packet: next cycle is IDLE with all readies low. The partial packet is abandoned; the bench checks no further beats are forwarded.
- Out-of-range grant is unreachable.

Test Plan:
- Reset, then input 0 sends a 3-beat packet (data 0x10, 0x11, 0x12; last on 0x12), m_tready=1 -> m_tid=0, beats appear on cycles 2, 3, 4 after the first request, busy falls after 0x12, ptr=1.
- All 4 inputs hold a 1-beat packet each continuously, m_tready=1 -> m_tid sequence 0,1,2,3,0,1...; one idle cycle between each grant.
- Input 2 sends a 4-beat packet with m_tready toggling 1,0,1,0... -> m_tdata holds stable while m_tready=0, exactly 4 beats forwarded, no beats are duplicated, s_tready[0,1,3] stay 0 throughout.
- Input 1 is locked and inputs 0 and 3 assert valid mid-packet -> input 1 completes; next grant is input 3 (ptr=2 search order 2,3,0), then input 0.
- Granted input drops s_tvalid for 3 cycles mid-packet -> m_tvalid=0 for those cycles, no grant change, packet resumes and completes.
- Reset pulsed for one cycle during beat 2 of a 5-beat packet -> next cycle all s_tready=0 and m_tvalid=0; after reset the first grant comes from ptr=0 order.
